// File: rtl/sr_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : sr_ifetch
// Purpose  : Credit-limited instruction fetch unit with in-order buffer,
//            in-flight PC queue and redirect kill of owed responses.
// Revision : 1.0
// ============================================================================
module sr_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int         CW      = $clog2(DEPTH + 1);
  localparam int         PW      = $clog2(DEPTH);
  localparam logic [CW:0] c_DEPTH = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_kill;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_pq_wr;
  logic [PW-1:0] r_pq_rd;
  logic [31:0]   r_fifo_pc  [DEPTH];
  logic [31:0]   r_fifo_ins [DEPTH];
  logic [31:0]   r_pcq      [DEPTH];

  logic          w_credit;
  logic          w_issue;
  logic          w_ret;
  logic          w_drop;
  logic          w_push;
  logic          w_pq_pop;
  logic          w_pop;
  logic [CW-1:0] w_out_nxt;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Buffered and owed entries together never exceed DEPTH, so the buffer cannot overflow.
  assign w_credit    = ({1'b0, r_out} + {1'b0, r_count}) < c_DEPTH;
  assign im_req      = rst_n & w_credit & ~redirect;
  assign im_addr     = {2'b00, r_fetch_pc[31:2]};
  assign w_issue     = im_req & im_ack;
  assign w_ret       = im_rvalid & (r_out != '0);
  assign w_drop      = (r_kill != '0);
  assign w_push      = w_ret & ~redirect & ~w_drop;
  assign w_pq_pop    = w_ret & ~w_drop;
  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid & instr_ready & ~redirect;
  assign instr       = r_fifo_ins[r_rd];
  assign instr_pc    = r_fifo_pc[r_rd];
  assign w_out_nxt   = r_out + CW'(w_issue) - CW'(w_ret);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_count    <= '0;
      r_kill     <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_pq_wr    <= '0;
      r_pq_rd    <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (redirect) begin
        // Everything still owed by memory belongs to the old path.
        r_fetch_pc <= redirect_pc;
        r_count    <= '0;
        r_kill     <= w_out_nxt;
        r_wr       <= '0;
        r_rd       <= '0;
        r_pq_wr    <= '0;
        r_pq_rd    <= '0;
      end else begin
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_pq_wr    <= f_inc(r_pq_wr);
        end
        if (w_pq_pop) begin
          r_pq_rd <= f_inc(r_pq_rd);
        end
        if (w_ret && w_drop) begin
          r_kill <= r_kill - CW'(1);
        end
        if (w_push) begin
          r_wr <= f_inc(r_wr);
        end
        if (w_pop) begin
          r_rd <= f_inc(r_rd);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_pcq[r_pq_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_fifo_pc[r_wr]  <= r_pcq[r_pq_rd];
      r_fifo_ins[r_wr] <= im_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_ifetch
// Purpose  : Randomized and directed bench for sr_ifetch against a queue model.
// Revision : 1.0
// ============================================================================
module tb_sr_ifetch;

  localparam int          DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  sr_ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rvalid(im_rvalid),
    .im_rdata(im_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit live; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; int cyc; } pop_t;

  infl_t infl[$];
  ent_t  bq[$];
  mreq_t mem_q[$];
  pop_t  popq[$];
  logic [31:0] issq[$];

  logic [31:0] m_pc;
  logic [31:0] exp_seq;
  int cyc = 0;
  int lat_min = 1, lat_max = 1;
  int n_vec = 0, n_err = 0;
  logic        s_req, s_valid;
  logic [31:0] s_addr;

  function automatic logic [31:0] f_mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rn, input bit redir, input logic [31:0] rpc,
                      input bit ack, input bit rdy, input bit stray);
    bit    rv, mrv, exp_req, pop, ret, issue;
    infl_t r;
    int    due;
    rst_n = rn; redirect = redir; redirect_pc = rpc; im_ack = ack; instr_ready = rdy;
    mrv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rv  = stray || mrv;
    im_rvalid = rv;
    im_rdata  = stray ? 32'hBAD0_BAD0 : (mrv ? f_mem(mem_q[0].addr) : $urandom);
    #1;
    s_req = im_req; s_addr = im_addr; s_valid = instr_valid;
    exp_req = rn && (infl.size() + bq.size() < DEPTH) && !redir;
    chk("im_req", {31'b0, im_req}, {31'b0, exp_req});
    if (exp_req) chk("im_addr", im_addr, m_pc >> 2);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, (bq.size() != 0)});
    if (bq.size() != 0) begin
      chk("instr", instr, bq[0].ins);
      chk("instr_pc", instr_pc, bq[0].pc);
    end
    if (rn && instr_valid && rdy && !redir) begin
      chk("pop_seq", instr_pc, exp_seq);
      chk("pop_data", instr, f_mem(instr_pc >> 2));
      popq.push_back('{instr_pc, cyc});
      exp_seq = instr_pc + 32'd4;
    end
    if (im_req && ack) issq.push_back(im_addr);
    issue = exp_req && ack;
    if (!rn) begin
      infl.delete(); bq.delete(); mem_q.delete();
      m_pc = RESET_PC; exp_seq = RESET_PC;
    end else begin
      pop = (bq.size() != 0) && rdy && !redir;
      ret = rv && (infl.size() != 0);
      if (pop) void'(bq.pop_front());
      if (ret) begin
        r = infl.pop_front();
        if (r.live && !redir) bq.push_back('{r.pc, im_rdata});
      end
      if (mrv && !stray) void'(mem_q.pop_front());
      if (issue) begin
        infl.push_back('{m_pc, 1'b1});
        due = cyc + $urandom_range(lat_max, lat_min);
        if (mem_q.size() > 0 && mem_q[$].due > due) due = mem_q[$].due;
        mem_q.push_back('{m_pc >> 2, due});
        m_pc = m_pc + 32'd4;
      end
      if (redir) begin
        bq.delete();
        foreach (infl[i]) infl[i].live = 1'b0;
        m_pc = rpc; exp_seq = rpc;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n, input bit ack, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, ack, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    popq.delete(); issq.delete();
  endtask

  initial begin
    logic [31:0] rpc;
    bit rn, rd;
    m_pc = RESET_PC; exp_seq = RESET_PC;
    @(negedge clk);

    // Reset state and first fetch after release
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("rst_req", {31'b0, s_req}, 32'd0);
    chk("rst_valid", {31'b0, s_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("first_req", {31'b0, s_req}, 32'd1);
    chk("first_addr", s_addr, 32'h0000_0040);

    // Streaming with 1-cycle memory: back-to-back delivery after fill
    do_reset(); lat_min = 1; lat_max = 1;
    run(14, 1'b1, 1'b1);
    chk("stream_n", {31'b0, (popq.size() >= 4)}, 32'd1);
    if (popq.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("stream_pc", popq[i].pc, 32'h100 + 32'(4 * i));
        chk("stream_gap", 32'(popq[i].cyc - popq[0].cyc), 32'(i));
      end

    // Decode stalled: exactly DEPTH issues, then im_req low until a pop
    do_reset();
    run(10, 1'b1, 1'b0);
    chk("stall_n", 32'(issq.size()), 32'd3);
    if (issq.size() == 3)
      for (int i = 0; i < 3; i++) chk("stall_addr", issq[i], 32'h40 + 32'(i));
    chk("stall_req", {31'b0, s_req}, 32'd0);
    run(1, 1'b0, 1'b1);
    run(1, 1'b0, 1'b0);
    chk("stall_resume", {31'b0, s_req}, 32'd1);

    // Two in flight at 0x10/0x14, redirect to 0x200
    do_reset(); lat_min = 4; lat_max = 4;
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
    run(1, 1'b1, 1'b1);
    chk("kill_a0", s_addr, 32'h4);
    run(1, 1'b1, 1'b1);
    chk("kill_a1", s_addr, 32'h5);
    step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
    popq.delete(); lat_min = 1; lat_max = 1;
    run(16, 1'b1, 1'b1);
    chk("kill_first", (popq.size() > 0) ? popq[0].pc : 32'hFFFF_FFFF, 32'h200);

    // Redirect coincident with a return and an attempted issue
    do_reset();
    run(1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
    chk("coinc_req", {31'b0, s_req}, 32'd0);
    popq.delete();
    run(12, 1'b1, 1'b1);
    chk("coinc_n", {31'b0, (popq.size() >= 2)}, 32'd1);
    if (popq.size() >= 2) begin
      chk("coinc_pc0", popq[0].pc, 32'h300);
      chk("coinc_pc1", popq[1].pc, 32'h304);
    end

    // Fetch PC wraps through zero
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0);
    popq.delete();
    run(14, 1'b1, 1'b1);
    chk("wrap_n", {31'b0, (popq.size() >= 4)}, 32'd1);
    if (popq.size() >= 4) begin
      chk("wrap_pc0", popq[0].pc, 32'hFFFF_FFF8);
      chk("wrap_pc1", popq[1].pc, 32'hFFFF_FFFC);
      chk("wrap_pc2", popq[2].pc, 32'h0000_0000);
      chk("wrap_pc3", popq[3].pc, 32'h0000_0004);
    end

    // Reset with a full buffer
    do_reset();
    run(10, 1'b1, 1'b0);
    chk("full_valid", {31'b0, s_valid}, 32'd1);
    do_reset();
    run(1, 1'b0, 1'b0);
    chk("mrst_valid", {31'b0, s_valid}, 32'd0);
    chk("mrst_addr", s_addr, 32'h40);
    run(10, 1'b1, 1'b1);
    chk("mrst_first", (popq.size() > 0) ? popq[0].pc : 32'hFFFF_FFFF, RESET_PC);

    // Stray response with nothing outstanding is ignored
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    run(1, 1'b0, 1'b1);
    chk("stray_valid", {31'b0, s_valid}, 32'd0);
    chk("stray_req", {31'b0, s_req}, 32'd1);
    run(10, 1'b1, 1'b1);
    chk("stray_first", (popq.size() > 0) ? popq[0].pc : 32'hFFFF_FFFF, RESET_PC);

    // Randomized traffic
    do_reset(); lat_min = 1; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      rpc = $urandom;
      rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
      rn = ($urandom_range(0, 249) != 0);
      rd = ($urandom_range(0, 29) == 0);
      step(rn, rd, rpc, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
